me_pp: RTL and testbench

//  Memory-access pipeline stage; consumes the EX->ME bundle (reg_w_en, rd_addr, mem_r/w_en, mem_sign, mem_whb, mem_data, sel_mem_res, res).

---
 rtl/me_pp_pkg.sv | 22 ++
 rtl/me_lane_align.sv | 61 ++++++
 rtl/me_pp.sv | 141 ++++++++++++++
 tb/tb_me_pp.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/me_pp_pkg.sv
// rtl/me_pp_pkg.sv - shared widths, access-width encodings and FSM states for the ME stage
package me_pp_pkg;

  localparam int DATA_WIDTH          = 32;
  localparam int REG_FILE_ADDR_WIDTH = 5;

  // One-hot access width carried from EX.
  localparam logic [2:0] WHB_WORD = 3'b100;
  localparam logic [2:0] WHB_HALF = 3'b010;
  localparam logic [2:0] WHB_BYTE = 3'b001;

  typedef enum logic {
    ME_IDLE   = 1'b0,
    ME_ACCESS = 1'b1
  } me_state_e;

  // True when the byte address is not naturally aligned for the access width.
  function automatic logic is_misaligned(input logic [2:0] whb, input logic [1:0] addr_lo);
    return ((whb == WHB_HALF) && addr_lo[0]) || ((whb == WHB_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/me_lane_align.sv
// rtl/me_lane_align.sv - byte-lane enables, store replication and load shift/extend
// Ports:
//   whb        one-hot access width (word/half/byte)
//   addr_lo    low two bits of the byte address
//   sign_ext   1 = sign-extend the load result
//   store_data LSB-justified store data
//   rdata      raw bus read word
//   be         byte enables for the bus
//   wdata      lane-replicated store data
//   load_data  shifted and extended load result
module me_lane_align
  import me_pp_pkg::*;
(
  input  logic [2:0]            whb,
  input  logic [1:0]            addr_lo,
  input  logic                  sign_ext,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [3:0]            be,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] load_data
);

  logic [1:0]            offset;
  logic [DATA_WIDTH-1:0] shifted;

  always_comb begin
    offset    = 2'b00;
    be        = 4'b0000;
    wdata     = '0;
    load_data = '0;
    // Offset is aligned down to the access width, so untrapped misaligned
    // accesses use the same lanes as their aligned-down address.
    case (whb)
      WHB_BYTE: begin
        offset = addr_lo;
        be     = 4'b0001 << addr_lo;
        wdata  = {4{store_data[7:0]}};
      end
      WHB_HALF: begin
        offset = {addr_lo[1], 1'b0};
        be     = 4'b0011 << {addr_lo[1], 1'b0};
        wdata  = {2{store_data[15:0]}};
      end
      WHB_WORD: begin
        offset = 2'b00;
        be     = 4'b1111;
        wdata  = store_data;
      end
      default: ;
    endcase
    shifted = rdata >> {offset, 3'b000};
    case (whb)
      WHB_BYTE: load_data = {{(DATA_WIDTH-8){sign_ext & shifted[7]}}, shifted[7:0]};
      WHB_HALF: load_data = {{(DATA_WIDTH-16){sign_ext & shifted[15]}}, shifted[15:0]};
      WHB_WORD: load_data = shifted;
      default:  load_data = '0;
    endcase
  end

endmodule

// File: rtl/me_pp.sv
// rtl/me_pp.sv - memory-access pipeline stage with req/ack data bus, timeout abort and forwarding
// Optional feature: define ME_MISALIGN_TRAP_EN to trap misaligned half/word accesses
// instead of issuing them aligned-down.
// Ports:
//   clk, _rst                      clock, asynchronous active-low reset
//   *_in                           EX->ME bundle, captured when stall is low
//   stall                          holds IF/ID/EX while a bus access is outstanding
//   dbus_req/we/addr/be/wdata      data-bus request, held stable until dbus_ack
//   dbus_rdata, dbus_ack           read data and same-cycle completion
//   bus_err                        one-cycle pulse when an access times out
//   misalign_exc                   misaligned access trapped (0 unless ME_MISALIGN_TRAP_EN)
//   reg_w_en_out, rd_addr_out, wb_data     WB write port
//   pb_reg_w_en, pb_rd_addr, pb_reg_data   forwarding copies of the WB port
//   pb_data_valid                  0 while the forwarded value is a pending load
module me_pp
  import me_pp_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic                           clk,
  input  logic                           _rst,
  input  logic                           reg_w_en_in,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] rd_addr_in,
  input  logic                           mem_r_en_in,
  input  logic                           mem_w_en_in,
  input  logic [2:0]                     mem_sign_in,
  input  logic [2:0]                     mem_whb_in,
  input  logic [DATA_WIDTH-1:0]          mem_data_in,
  input  logic                           sel_mem_res_in,
  input  logic [DATA_WIDTH-1:0]          res_in,
  output logic                           stall,
  output logic                           dbus_req,
  output logic                           dbus_we,
  output logic [DATA_WIDTH-1:0]          dbus_addr,
  output logic [3:0]                     dbus_be,
  output logic [DATA_WIDTH-1:0]          dbus_wdata,
  input  logic [DATA_WIDTH-1:0]          dbus_rdata,
  input  logic                           dbus_ack,
  output logic                           bus_err,
  output logic                           misalign_exc,
  output logic                           reg_w_en_out,
  output logic [REG_FILE_ADDR_WIDTH-1:0] rd_addr_out,
  output logic [DATA_WIDTH-1:0]          wb_data,
  output logic                           pb_reg_w_en,
  output logic [REG_FILE_ADDR_WIDTH-1:0] pb_rd_addr,
  output logic [DATA_WIDTH-1:0]          pb_reg_data,
  output logic                           pb_data_valid
);

  logic                           reg_w_en_q, mem_r_en_q, mem_w_en_q, sel_mem_res_q;
  logic [REG_FILE_ADDR_WIDTH-1:0] rd_addr_q;
  logic [2:0]                     mem_sign_q, mem_whb_q;
  logic [DATA_WIDTH-1:0]          mem_data_q, res_q;

  me_state_e        state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             access, timeout, trap_in;

  logic [3:0]            be_raw;
  logic [DATA_WIDTH-1:0] wdata_raw, load_ext;

`ifdef ME_MISALIGN_TRAP_EN
  // Trap is decided on the incoming op so a trapped op never enters ACCESS.
  assign trap_in      = is_misaligned(mem_whb_in, res_in[1:0]);
  assign misalign_exc = (mem_r_en_q | mem_w_en_q) && is_misaligned(mem_whb_q, res_q[1:0]);
`else
  assign trap_in      = 1'b0;
  assign misalign_exc = 1'b0;
`endif

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      reg_w_en_q    <= 1'b0;
      rd_addr_q     <= '0;
      mem_r_en_q    <= 1'b0;
      mem_w_en_q    <= 1'b0;
      mem_sign_q    <= '0;
      mem_whb_q     <= '0;
      mem_data_q    <= '0;
      sel_mem_res_q <= 1'b0;
      res_q         <= '0;
      state_q       <= ME_IDLE;
      wait_cnt_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (!stall) begin
        reg_w_en_q    <= reg_w_en_in;
        rd_addr_q     <= rd_addr_in;
        mem_r_en_q    <= mem_r_en_in;
        mem_w_en_q    <= mem_w_en_in;
        mem_sign_q    <= mem_sign_in;
        mem_whb_q     <= mem_whb_in;
        mem_data_q    <= mem_data_in;
        sel_mem_res_q <= sel_mem_res_in;
        res_q         <= res_in;
      end
    end
  end

  me_lane_align u_lane_align (
    .whb        (mem_whb_q),
    .addr_lo    (res_q[1:0]),
    .sign_ext   (|mem_sign_q),
    .store_data (mem_data_q),
    .rdata      (dbus_rdata),
    .be         (be_raw),
    .wdata      (wdata_raw),
    .load_data  (load_ext)
  );

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = '0;
    access       = (state_q == ME_ACCESS);
    // An ack arriving on the last allowed cycle wins over the abort.
    timeout      = access && (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) && !dbus_ack;
    stall        = access && !dbus_ack && !timeout;
    bus_err      = timeout;
    dbus_req     = access;
    dbus_we      = access && mem_w_en_q;
    dbus_addr    = access ? {res_q[DATA_WIDTH-1:2], 2'b00} : '0;
    dbus_be      = access ? be_raw : 4'b0000;
    dbus_wdata   = (access && mem_w_en_q) ? wdata_raw : '0;
    reg_w_en_out = reg_w_en_q && !stall && !bus_err && !misalign_exc;
    rd_addr_out  = rd_addr_q;
    wb_data      = sel_mem_res_q ? load_ext : res_q;
    if (stall) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end else begin
      // Next op is captured this edge; a mem op goes straight to ACCESS with no idle bubble.
      state_d = ((mem_r_en_in | mem_w_en_in) && !trap_in) ? ME_ACCESS : ME_IDLE;
    end
    pb_reg_w_en   = reg_w_en_out;
    pb_rd_addr    = rd_addr_out;
    pb_reg_data   = wb_data;
    pb_data_valid = !(access && mem_r_en_q && !dbus_ack);
  end

endmodule

// File: tb/tb_me_pp.sv
// tb/tb_me_pp.sv - directed self-checking bench for me_pp
module tb_me_pp;

  logic        clk = 1'b0;
  logic        _rst;
  logic        reg_w_en_in, mem_r_en_in, mem_w_en_in, sel_mem_res_in;
  logic [4:0]  rd_addr_in;
  logic [2:0]  mem_sign_in, mem_whb_in;
  logic [31:0] mem_data_in, res_in;
  logic        stall, dbus_req, dbus_we, dbus_ack, bus_err, misalign_exc;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata, wb_data, pb_reg_data;
  logic [3:0]  dbus_be;
  logic        reg_w_en_out, pb_reg_w_en, pb_data_valid;
  logic [4:0]  rd_addr_out, pb_rd_addr;

  int total = 0;
  int bad   = 0;

  me_pp dut (
    .clk(clk), ._rst(_rst),
    .reg_w_en_in(reg_w_en_in), .rd_addr_in(rd_addr_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .mem_sign_in(mem_sign_in), .mem_whb_in(mem_whb_in),
    .mem_data_in(mem_data_in), .sel_mem_res_in(sel_mem_res_in), .res_in(res_in),
    .stall(stall), .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata), .dbus_rdata(dbus_rdata), .dbus_ack(dbus_ack),
    .bus_err(bus_err), .misalign_exc(misalign_exc), .reg_w_en_out(reg_w_en_out),
    .rd_addr_out(rd_addr_out), .wb_data(wb_data), .pb_reg_w_en(pb_reg_w_en),
    .pb_rd_addr(pb_rd_addr), .pb_reg_data(pb_reg_data), .pb_data_valid(pb_data_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic set_op(input logic rwe, input logic [4:0] rd, input logic r, input logic w,
                        input logic [2:0] sgn, input logic [2:0] whb, input logic [31:0] data,
                        input logic sel, input logic [31:0] res);
    reg_w_en_in = rwe; rd_addr_in = rd; mem_r_en_in = r; mem_w_en_in = w;
    mem_sign_in = sgn; mem_whb_in = whb; mem_data_in = data; sel_mem_res_in = sel; res_in = res;
  endtask

  task automatic set_nop();
    set_op(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 3'd0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    _rst = 1'b0; dbus_ack = 1'b0; dbus_rdata = 32'd0; set_nop();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({stall, dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, bus_err, misalign_exc} !== '0) begin
      bad++; $display("FAIL reset_bus got stall=%b req=%b we=%b addr=%h be=%b wdata=%h err=%b mis=%b want all 0",
                      stall, dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, bus_err, misalign_exc);
    end
    total++;
    if ({reg_w_en_out, rd_addr_out, wb_data, pb_reg_w_en, pb_rd_addr, pb_reg_data} !== '0) begin
      bad++; $display("FAIL reset_wb got wen=%b rd=%0d wb=%h pbw=%b pbrd=%0d pbd=%h want all 0",
                      reg_w_en_out, rd_addr_out, wb_data, pb_reg_w_en, pb_rd_addr, pb_reg_data);
    end
    @(negedge clk);
    _rst = 1'b1;
    step();
  endtask

  task automatic test_lw_wait();
    int stall_n = 0;
    set_op(1'b1, 5'd5, 1'b1, 1'b0, 3'd1, 3'b100, 32'd0, 1'b1, 32'h100);
    step();
    set_nop();
    total++;
    if (dbus_req !== 1'b1 || dbus_we !== 1'b0 || dbus_be !== 4'b1111 || dbus_addr !== 32'h100) begin
      bad++; $display("FAIL lw_bus got req=%b we=%b be=%b addr=%h want 1 0 1111 00000100", dbus_req, dbus_we, dbus_be, dbus_addr);
    end
    total++;
    if (pb_data_valid !== 1'b0 || reg_w_en_out !== 1'b0) begin
      bad++; $display("FAIL lw_pending got pbv=%b wen=%b want 0 0", pb_data_valid, reg_w_en_out);
    end
    for (int i = 0; i < 3; i++) begin
      if (stall === 1'b1) stall_n++;
      step();
    end
    total++;
    if (stall_n !== 3) begin
      bad++; $display("FAIL lw_stall_cycles got %0d want 3", stall_n);
    end
    dbus_ack = 1'b1; dbus_rdata = 32'hDEADBEEF;
    #1;
    total++;
    if (stall !== 1'b0 || wb_data !== 32'hDEADBEEF || reg_w_en_out !== 1'b1 || rd_addr_out !== 5'd5) begin
      bad++; $display("FAIL lw_done got stall=%b wb=%h wen=%b rd=%0d want 0 deadbeef 1 5", stall, wb_data, reg_w_en_out, rd_addr_out);
    end
    total++;
    if (pb_data_valid !== 1'b1 || pb_reg_data !== 32'hDEADBEEF || pb_reg_w_en !== 1'b1) begin
      bad++; $display("FAIL lw_fwd got pbv=%b pbd=%h pbw=%b want 1 deadbeef 1", pb_data_valid, pb_reg_data, pb_reg_w_en);
    end
    step();
    dbus_ack = 1'b0;
    #1;
    total++;
    if (reg_w_en_out !== 1'b0 || dbus_req !== 1'b0) begin
      bad++; $display("FAIL lw_once got wen=%b req=%b want 0 0", reg_w_en_out, dbus_req);
    end
  endtask

  task automatic test_lb();
    set_op(1'b1, 5'd7, 1'b1, 1'b0, 3'd1, 3'b001, 32'd0, 1'b1, 32'h103);
    step();
    dbus_ack = 1'b1; dbus_rdata = 32'h80000000;
    #1;
    total++;
    if (stall !== 1'b0 || dbus_be !== 4'b1000 || wb_data !== 32'hFFFFFF80 || reg_w_en_out !== 1'b1) begin
      bad++; $display("FAIL lb_signed got stall=%b be=%b wb=%h wen=%b want 0 1000 ffffff80 1", stall, dbus_be, wb_data, reg_w_en_out);
    end
    set_op(1'b1, 5'd8, 1'b1, 1'b0, 3'd0, 3'b001, 32'd0, 1'b1, 32'h103);
    step();
    total++;
    if (dbus_req !== 1'b1 || stall !== 1'b0 || wb_data !== 32'h00000080 || rd_addr_out !== 5'd8) begin
      bad++; $display("FAIL lbu_b2b got req=%b stall=%b wb=%h rd=%0d want 1 0 00000080 8", dbus_req, stall, wb_data, rd_addr_out);
    end
    set_nop();
    step();
    dbus_ack = 1'b0;
    #1;
  endtask

  task automatic test_sh();
    set_op(1'b0, 5'd0, 1'b0, 1'b1, 3'd0, 3'b010, 32'h1234ABCD, 1'b0, 32'h102);
    step();
    total++;
    if (dbus_we !== 1'b1 || dbus_be !== 4'b1100 || dbus_wdata !== 32'hABCDABCD || dbus_addr !== 32'h100) begin
      bad++; $display("FAIL sh_bus got we=%b be=%b wdata=%h addr=%h want 1 1100 abcdabcd 00000100", dbus_we, dbus_be, dbus_wdata, dbus_addr);
    end
    dbus_ack = 1'b1;
    #1;
    total++;
    if (stall !== 1'b0 || reg_w_en_out !== 1'b0) begin
      bad++; $display("FAIL sh_done got stall=%b wen=%b want 0 0", stall, reg_w_en_out);
    end
    set_nop();
    step();
    dbus_ack = 1'b0;
    #1;
  endtask

  task automatic test_timeout();
    int stall_n = 0;
    int err_cyc = 0;
    int wrote   = 0;
    set_op(1'b1, 5'd9, 1'b1, 1'b0, 3'd0, 3'b100, 32'd0, 1'b1, 32'h300);
    step();
    set_nop();
    for (int c = 1; c <= 20; c++) begin
      if (stall === 1'b1) stall_n++;
      if (bus_err === 1'b1 && err_cyc == 0) err_cyc = c;
      if (reg_w_en_out === 1'b1) wrote++;
      if (stall !== 1'b1) break;
      step();
    end
    total++;
    if (stall_n !== 15) begin
      bad++; $display("FAIL to_stall_cycles got %0d want 15", stall_n);
    end
    total++;
    if (err_cyc !== 16) begin
      bad++; $display("FAIL to_err_cycle got %0d want 16", err_cyc);
    end
    total++;
    if (wrote !== 0) begin
      bad++; $display("FAIL to_no_write got %0d writes want 0", wrote);
    end
    step();
    total++;
    if (bus_err !== 1'b0 || dbus_req !== 1'b0) begin
      bad++; $display("FAIL to_after got err=%b req=%b want 0 0", bus_err, dbus_req);
    end
  endtask

  task automatic test_misalign();
    set_op(1'b1, 5'd10, 1'b1, 1'b0, 3'd0, 3'b100, 32'd0, 1'b1, 32'h101);
    step();
`ifdef ME_MISALIGN_TRAP_EN
    total++;
    if (misalign_exc !== 1'b1 || dbus_req !== 1'b0 || reg_w_en_out !== 1'b0 || stall !== 1'b0) begin
      bad++; $display("FAIL mis_trap got mis=%b req=%b wen=%b stall=%b want 1 0 0 0", misalign_exc, dbus_req, reg_w_en_out, stall);
    end
    set_nop();
    step();
    total++;
    if (misalign_exc !== 1'b0) begin
      bad++; $display("FAIL mis_clear got %b want 0", misalign_exc);
    end
`else
    total++;
    if (misalign_exc !== 1'b0 || dbus_req !== 1'b1 || dbus_addr !== 32'h100 || dbus_be !== 4'b1111) begin
      bad++; $display("FAIL mis_aligned_down got mis=%b req=%b addr=%h be=%b want 0 1 00000100 1111", misalign_exc, dbus_req, dbus_addr, dbus_be);
    end
    dbus_ack = 1'b1; dbus_rdata = 32'h11223344;
    #1;
    total++;
    if (wb_data !== 32'h11223344 || reg_w_en_out !== 1'b1) begin
      bad++; $display("FAIL mis_load got wb=%h wen=%b want 11223344 1", wb_data, reg_w_en_out);
    end
    set_nop();
    step();
    dbus_ack = 1'b0;
    #1;
`endif
  endtask

  task automatic test_back_to_back_reset();
    set_op(1'b1, 5'd3, 1'b0, 1'b0, 3'd0, 3'd0, 32'd0, 1'b0, 32'h55);
    step();
    total++;
    if (reg_w_en_out !== 1'b1 || wb_data !== 32'h55 || rd_addr_out !== 5'd3 || dbus_req !== 1'b0) begin
      bad++; $display("FAIL b2b_add got wen=%b wb=%h rd=%0d req=%b want 1 00000055 3 0", reg_w_en_out, wb_data, rd_addr_out, dbus_req);
    end
    set_op(1'b1, 5'd4, 1'b1, 1'b0, 3'd0, 3'b100, 32'd0, 1'b1, 32'h200);
    step();
    total++;
    if (dbus_req !== 1'b1 || stall !== 1'b1) begin
      bad++; $display("FAIL b2b_lw got req=%b stall=%b want 1 1", dbus_req, stall);
    end
    set_op(1'b1, 5'd6, 1'b0, 1'b0, 3'd0, 3'd0, 32'd0, 1'b0, 32'h77);
    #2;
    _rst = 1'b0;
    #1;
    total++;
    if ({stall, dbus_req, dbus_addr, dbus_be, reg_w_en_out, rd_addr_out, wb_data, pb_reg_w_en} !== '0) begin
      bad++; $display("FAIL b2b_async_rst got stall=%b req=%b addr=%h be=%b wen=%b rd=%0d wb=%h want all 0",
                      stall, dbus_req, dbus_addr, dbus_be, reg_w_en_out, rd_addr_out, wb_data);
    end
    #1;
    _rst = 1'b1;
    step();
    total++;
    if (dbus_req !== 1'b0 || stall !== 1'b0 || reg_w_en_out !== 1'b1 || wb_data !== 32'h77 || rd_addr_out !== 5'd6) begin
      bad++; $display("FAIL b2b_after_rst got req=%b stall=%b wen=%b wb=%h rd=%0d want 0 0 1 00000077 6",
                      dbus_req, stall, reg_w_en_out, wb_data, rd_addr_out);
    end
    set_nop();
    step();
  endtask

  initial begin
    test_reset();
    test_lw_wait();
    test_lb();
    test_sh();
    test_timeout();
    test_misalign();
    test_back_to_back_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
